pool_fmap_ii_writer: RTL and testbench

//  Stage feeding the layer-II feature-map store: 2x2/stride-2 max-pool of the conv-1 output stream.

---
 rtl/fmap_pkg.sv | 30 +++
 rtl/pool_line_buf.sv | 34 +++
 rtl/pool_fmap_ii_writer.sv | 172 +++++++++++++++++
 tb/tb_pool_fmap_ii_writer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fmap_pkg.sv
// Shared constants, types and helpers for the layer-II feature-map writer.
package fmap_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 3;
  localparam int NCH        = 8;
  localparam int IN_DIM     = 24;
  localparam int OUT_DIM    = IN_DIM / 2;
  localparam int NBANK      = 144;

  // Derived index widths.
  localparam int CNT_W  = $clog2(IN_DIM);
  localparam int K_W    = $clog2(OUT_DIM);
  localparam int BANK_W = $clog2(NBANK);

  typedef logic signed [DATA_WIDTH-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Signed maximum of two pixels; on a tie both operands are equal.
  function automatic pixel_t smax(input pixel_t a, input pixel_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// One row of horizontal pair maxima, held between an even input row and the
// following odd row. One write and one combinational read per cycle.
module pool_line_buf
  import fmap_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [K_W-1:0]        wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [K_W-1:0]        rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [OUT_DIM];

  // Entry storage: cleared on reset, one entry written per accepted even-row odd-col pixel.
  // NOTE: this is a small register array, not a RAM macro, so resetting every
  // entry is cheap and keeps a post-reset frame free of stale maxima.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OUT_DIM; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en && (wr_idx < K_W'(OUT_DIM))) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = (rd_idx < K_W'(OUT_DIM)) ? mem[rd_idx] : '0;

endmodule

// File: rtl/pool_fmap_ii_writer.sv
// 2x2 / stride-2 max-pool of the conv-1 pixel stream, writing each pooled value
// into the 144-bank layer-II feature-map store (bank = pooled position,
// address = channel).
module pool_fmap_ii_writer
  import fmap_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [NBANK-1:0]      fmap_wr_en,
  output logic [ADDR_WIDTH-1:0] fmap_wr_addr [NBANK],
  output logic [DATA_WIDTH-1:0] fmap_wr_data [NBANK],
  output logic                  busy,
  output logic                  done
);

  state_t state_q, state_d;

  logic [CNT_W-1:0]      row_q, col_q;
  logic [ADDR_WIDTH-1:0] ch_q;
  pixel_t                part_q;

  logic [NBANK-1:0]      wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;

  logic                  accept;
  logic                  col_last, row_last, ch_last, frame_last;
  pixel_t                pix;
  logic [K_W-1:0]        k_idx;
  logic [BANK_W-1:0]     bank_idx;
  logic [DATA_WIDTH-1:0] lbuf_rd;
  logic                  lbuf_wr_en;
  pixel_t                top_max;
  pixel_t                col_max;
  logic                  emit;

  // Position decode of the pixel currently presented.
  assign accept     = in_valid && (state_q == RUN);
  assign col_last   = (col_q == CNT_W'(IN_DIM - 1));
  assign row_last   = (row_q == CNT_W'(IN_DIM - 1));
  assign ch_last    = (ch_q == ADDR_WIDTH'(NCH - 1));
  assign frame_last = col_last && row_last && ch_last;

  assign pix      = pixel_t'(in_data);
  assign k_idx    = K_W'(col_q >> 1);
  assign bank_idx = BANK_W'(row_q >> 1) * BANK_W'(OUT_DIM) + BANK_W'(col_q >> 1);

  // Window reduction: top pair max (part vs. pixel) and vertical max against the line buffer.
  assign top_max    = smax(part_q, pix);
  assign col_max    = smax(pixel_t'(lbuf_rd), pix);
  assign lbuf_wr_en = accept && !row_q[0] && col_q[0];
  assign emit       = accept && row_q[0] && col_q[0];

  pool_line_buf u_line_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (lbuf_wr_en),
    .wr_idx  (k_idx),
    .wr_data (top_max),
    .rd_idx  (k_idx),
    .rd_data (lbuf_rd)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and status outputs.
  // NOTE: every signal driven here gets a default first so no path through the
  // case leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept && frame_last) state_d = FLUSH;
      end
      FLUSH: begin
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Raster counters: col fastest, then row, then channel; advance only on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
      ch_q  <= '0;
    end else if ((state_q == IDLE) && start) begin
      col_q <= '0;
      row_q <= '0;
      ch_q  <= '0;
    end else if (accept) begin
      if (col_last) begin
        col_q <= '0;
        if (row_last) begin
          row_q <= '0;
          ch_q  <= ch_last ? '0 : ch_q + 1'b1;
        end else begin
          row_q <= row_q + 1'b1;
        end
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  // Partial-window register: top-left pixel on even rows, column max on odd rows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      part_q <= '0;
    end else if (accept && !col_q[0]) begin
      part_q <= row_q[0] ? col_max : pix;
    end
  end

  // One-hot bank decode of the pooled position for the write about to be issued.
  always_comb begin
    wr_en_d = '0;
    for (int b = 0; b < NBANK; b++) begin
      if (emit && (bank_idx == BANK_W'(b))) wr_en_d[b] = 1'b1;
    end
  end

  // Store write-port registers: enable pulses for one cycle, address/data hold between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= wr_en_d;
      if (emit) begin
        wr_addr_q <= ch_q;
        wr_data_q <= top_max;
      end
    end
  end

  assign fmap_wr_en = wr_en_q;

  // Address and data are common to all banks; only the enable selects the bank.
  for (genvar b = 0; b < NBANK; b++) begin : g_bcast
    assign fmap_wr_addr[b] = wr_addr_q;
    assign fmap_wr_data[b] = wr_data_q;
  end

endmodule

// File: tb/tb_pool_fmap_ii_writer.sv
// Self-checking bench for pool_fmap_ii_writer: full frames of directed data,
// a table of 2x2 window vectors, bubbles, stray starts and mid-frame reset.
module tb_pool_fmap_ii_writer;
  import fmap_pkg::*;

  localparam int NPIX   = NCH * IN_DIM * IN_DIM;
  localparam int NWRITE = NCH * NBANK;
  localparam int NVEC   = 12;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  start;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic [NBANK-1:0]      fmap_wr_en;
  logic [ADDR_WIDTH-1:0] fmap_wr_addr [NBANK];
  logic [DATA_WIDTH-1:0] fmap_wr_data [NBANK];
  logic                  busy;
  logic                  done;

  pool_fmap_ii_writer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .fmap_wr_en   (fmap_wr_en),
    .fmap_wr_addr (fmap_wr_addr),
    .fmap_wr_data (fmap_wr_data),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Window vectors: a=top-left, b=top-right, c=bottom-left, d=bottom-right.
  typedef struct {
    logic signed [15:0] a, b, c, d;
    logic signed [15:0] exp;
  } win_vec_t;

  win_vec_t tbl [NVEC];

  int n_vec  = 0;
  int n_fail = 0;

  logic [31:0] wq [$];
  bit          written [NBANK][NCH];
  int          neg_cnt     = 0;
  int          done_cnt    = 0;
  int          done_cyc    = 0;
  int          last_wr_cyc = 0;
  logic        acc_at_edge = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic signed [15:0] pix(input int mode, input int ch, input int r, input int c);
    int bank, v, pos;
    bank = (r / 2) * OUT_DIM + (c / 2);
    v    = (bank + ch) % NVEC;
    pos  = (r % 2) * 2 + (c % 2);
    case (mode)
      0: return 16'(ch * 1000 + r * 24 + c);
      1: begin
        case (pos)
          0: return tbl[v].a;
          1: return tbl[v].b;
          2: return tbl[v].c;
          default: return tbl[v].d;
        endcase
      end
      default: return (pos == 0) ? -16'sd1 : 16'(-300 - r - c);
    endcase
  endfunction

  function automatic logic signed [15:0] exp_val(input int mode, input int ch, input int bank);
    int i, j;
    i = bank / OUT_DIM;
    j = bank % OUT_DIM;
    case (mode)
      0: return 16'(ch * 1000 + (2 * i + 1) * 24 + 2 * j + 1);
      1: return tbl[(bank + ch) % NVEC].exp;
      default: return -16'sd1;
    endcase
  endfunction

  // Accept observed at each rising edge, using the pre-edge handshake values.
  always @(posedge clk) acc_at_edge <= in_valid & in_ready;

  // Write/done monitor, sampled mid-cycle.
  always @(negedge clk) begin
    check("ready_vs_busy", in_ready, busy);
    if (fmap_wr_en != '0) begin
      int b;
      b = 0;
      for (int i = 0; i < NBANK; i++) if (fmap_wr_en[i]) b = i;
      check("wr_onehot", $onehot0(fmap_wr_en), 1);
      check("wr_after_accept", acc_at_edge, 1);
      check("wr_unique", written[b][fmap_wr_addr[b]], 0);
      written[b][fmap_wr_addr[b]] = 1'b1;
      wq.push_back({8'(b), 8'(fmap_wr_addr[b]), fmap_wr_data[b]});
      last_wr_cyc = neg_cnt;
    end
    if (done) begin
      done_cnt++;
      done_cyc = neg_cnt;
    end
    neg_cnt++;
  end

  task automatic clear_log();
    wq.delete();
    for (int b = 0; b < NBANK; b++)
      for (int a = 0; a < NCH; a++) written[b][a] = 1'b0;
  endtask

  // Pulse start from IDLE; leaves the bench at the negedge after the start edge.
  task automatic pulse_start();
    @(negedge clk);
    check("idle_ready", in_ready, 0);
    check("idle_busy", busy, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("run_busy", busy, 1);
  endtask

  // Feed pixels 0..n-1 of a frame; returns at the negedge after the last accept.
  task automatic feed(input int mode, input int n, input bit bubbles, input bit start_mid);
    int idx, guard, ch, r, c;
    bit vld, acc;
    idx   = 0;
    guard = 0;
    while (idx < n && guard < 30000) begin
      vld = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
      ch  = idx / (IN_DIM * IN_DIM);
      r   = (idx % (IN_DIM * IN_DIM)) / IN_DIM;
      c   = idx % IN_DIM;
      in_valid = vld;
      in_data  = vld ? pix(mode, ch, r, c) : 16'($urandom);
      start    = start_mid && (idx == 1000);
      acc      = vld && in_ready;
      @(negedge clk);
      guard++;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (idx < n) check("feed_timeout", idx, n);
  endtask

  task automatic run_frame(input int mode, input bit bubbles, input bit start_mid);
    int d0, w, nchk;
    clear_log();
    d0 = done_cnt;
    pulse_start();
    feed(mode, NPIX, bubbles, start_mid);
    w = 0;
    while (!done && w < 8) begin
      @(negedge clk);
      w++;
    end
    check("done_seen", done, 1);
    // A start on the done cycle must not launch another frame.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("start_on_done_ignored", busy, 0);
    check("done_count", done_cnt - d0, 1);
    check("done_after_last_write", done_cyc - last_wr_cyc, 1);
    check("write_count", wq.size(), NWRITE);
    nchk = (wq.size() < NWRITE) ? wq.size() : NWRITE;
    for (int n = 0; n < nchk; n++) begin
      check("write", wq[n], {8'(n % NBANK), 8'(n / NBANK), exp_val(mode, n / NBANK, n % NBANK)});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    tbl[0]  = '{16'sd1,      16'sd2,      16'sd3,      16'sd4,      16'sd4};
    tbl[1]  = '{16'sd4,      16'sd3,      16'sd2,      16'sd1,      16'sd4};
    tbl[2]  = '{-16'sd5,     -16'sd6,     -16'sd7,     -16'sd8,     -16'sd5};
    tbl[3]  = '{-16'sd1,     -16'sd300,   -16'sd300,   -16'sd300,   -16'sd1};
    tbl[4]  = '{16'sd32767,  -16'sd32768, 16'sd0,      16'sd0,      16'sd32767};
    tbl[5]  = '{-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768};
    tbl[6]  = '{16'sd7,      16'sd7,      16'sd7,      16'sd7,      16'sd7};
    tbl[7]  = '{16'sd0,      -16'sd1,     16'sd100,    -16'sd100,   16'sd100};
    tbl[8]  = '{-16'sd2,     16'sd50,     -16'sd3,     -16'sd4,     16'sd50};
    tbl[9]  = '{-16'sd32768, -16'sd32767, -16'sd32766, -16'sd32765, -16'sd32765};
    tbl[10] = '{16'sd10,     16'sd20,     16'sd30,     16'sd20,     16'sd30};
    tbl[11] = '{16'sd100,    -16'sd100,   16'sd100,    16'sd99,     16'sd100};

    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    #2;
    check("rst_wr_en", fmap_wr_en, 0);
    check("rst_addr", fmap_wr_addr[0], 0);
    check("rst_data", fmap_wr_data[NBANK-1], 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_frame(0, 1'b0, 1'b0);   // ramp data
    run_frame(2, 1'b0, 1'b0);   // negative data, max top-left
    run_frame(1, 1'b0, 1'b0);   // window vector table
    run_frame(0, 1'b1, 1'b0);   // ramp with bubbles
    run_frame(0, 1'b0, 1'b1);   // stray start during RUN
    run_frame(0, 1'b0, 1'b0);   // second frame after start on done cycle

    // Mid-frame reset at ch=3, row=10.
    clear_log();
    pulse_start();
    feed(0, 3 * IN_DIM * IN_DIM + 10 * IN_DIM, 1'b0, 1'b0);
    check("pre_reset_addr", fmap_wr_addr[0], 3);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_wr_en", fmap_wr_en, 0);
    check("mid_rst_addr", fmap_wr_addr[7], 0);
    check("mid_rst_data", fmap_wr_data[7], 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("mid_rst_no_done", done_cnt - d0, 0);
    check("mid_rst_idle", busy, 0);
    run_frame(0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
